operand_entry_ctrl: RTL

//  Consumes the one-cycle button pulses produced by the debouncers and sequences operand entry for the

---
 rtl/operand_entry_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/operand_entry_ctrl.sv
// Operand entry sequencer: captures switch values as A then B, pulses start to the
// arithmetic core, waits for done (with timeout) and holds the result for display.
module operand_entry_ctrl #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_p,
    input  logic             clear_p,
    input  logic [WIDTH-1:0] sw,
    input  logic             done,
    input  logic [WIDTH-1:0] result_in,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             start,
    output logic [WIDTH-1:0] disp,
    output logic [1:0]       stage,
    output logic             err
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_ENTER_A,
        S_ENTER_B,
        S_START,
        S_WAIT,
        S_SHOW
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] opa_nx, opb_nx;
    logic [WIDTH-1:0] result_q, result_nx;
    logic             err_nx, start_nx;
    logic [CW-1:0]    cnt_q, cnt_nx;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_ENTER_A;
            operand_a <= '0;
            operand_b <= '0;
            result_q  <= '0;
            err       <= 1'b0;
            start     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nx;
            operand_a <= opa_nx;
            operand_b <= opb_nx;
            result_q  <= result_nx;
            err       <= err_nx;
            start     <= start_nx;
            cnt_q     <= cnt_nx;
        end
    end

    // start is registered: it is raised on the edge that enters START, so it is
    // high for exactly the one cycle spent in START.
    always_comb begin
        state_nx  = state;
        opa_nx    = operand_a;
        opb_nx    = operand_b;
        result_nx = result_q;
        err_nx    = err;
        start_nx  = 1'b0;
        cnt_nx    = cnt_q;
        if (clear_p) begin
            state_nx  = S_ENTER_A;
            opa_nx    = '0;
            opb_nx    = '0;
            result_nx = '0;
            err_nx    = 1'b0;
            cnt_nx    = '0;
        end else begin
            case (state)
                S_ENTER_A: begin
                    if (next_p) begin
                        opa_nx   = sw;
                        state_nx = S_ENTER_B;
                    end
                end
                S_ENTER_B: begin
                    if (next_p) begin
                        opb_nx   = sw;
                        start_nx = 1'b1;
                        state_nx = S_START;
                    end
                end
                S_START: begin
                    cnt_nx   = '0;
                    state_nx = S_WAIT;
                end
                S_WAIT: begin
                    // done has priority over a timeout landing on the same edge
                    if (done) begin
                        result_nx = result_in;
                        err_nx    = 1'b0;
                        state_nx  = S_SHOW;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        result_nx = '0;
                        err_nx    = 1'b1;
                        state_nx  = S_SHOW;
                    end else begin
                        cnt_nx = cnt_q + CW'(1);
                    end
                end
                S_SHOW: begin
                    if (next_p) state_nx = S_ENTER_A;
                end
                default: state_nx = S_ENTER_A;
            endcase
        end
    end

    always_comb begin
        disp  = '0;
        stage = 2'd0;
        case (state)
            S_ENTER_A: begin disp = sw;        stage = 2'd0; end
            S_ENTER_B: begin disp = sw;        stage = 2'd1; end
            S_START,
            S_WAIT:    begin disp = operand_b; stage = 2'd2; end
            S_SHOW:    begin disp = result_q;  stage = 2'd3; end
            default:   begin disp = '0;        stage = 2'd0; end
        endcase
    end

    a_start_single: assert property (@(posedge clk) disable iff (!rst) start |=> !start);

endmodule
